// File: rtl/bcd_to_bin_serial_if.sv
// Request/result bundle for the serial BCD-to-binary converter.
// The master drives the request (start + packed BCD word) and the slave
// returns status strobes and the held binary result.
interface bcd_to_bin_serial_if #(
    parameter int DIGITS = 3,
    parameter int BW     = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BW-1:0]         bin;

    modport master (
        output start, bcd,
        input  busy, done, err, bin
    );

    modport slave (
        input  start, bcd,
        output busy, done, err, bin
    );
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// The packed BCD word sits above a BW-bit binary field in one shift register;
// each CONV cycle shifts right by one and pulls every BCD nibble that is >= 8
// back by 3. After BW shifts the binary field holds the value and the BCD
// field has drained to zero. Words containing a nibble > 9 skip conversion
// and report ERR with BIN = 0.
module bcd_to_bin_serial #(
    parameter int DIGITS = 3,
    parameter int BW     = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    bcd_to_bin_serial_if.slave s_if
);
    localparam int    SR_W  = 4*DIGITS + BW;
    localparam int    CNT_W = $clog2(BW + 1);
    localparam longint MAXV = (64'd10 ** DIGITS) - 64'd1;

    // The largest DIGITS-digit decimal value must fit in BW bits.
    if ((64'd2 ** BW) <= MAXV) begin : g_param_check
        $error("bcd_to_bin_serial: BW too small for DIGITS");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SR_W-1:0]    r_sr;
    logic [SR_W-1:0]    w_sr_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BW-1:0]      r_bin;
    logic               r_err;
    logic               w_bcd_bad;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    // True when any nibble of the word is not a decimal digit.
    function automatic logic f_bcd_invalid(input logic [4*DIGITS-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then correct BCD nibbles.
    function automatic logic [SR_W-1:0] f_shift_fix(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] s;
        s = sr >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[BW + 4*d +: 4] >= 4'd8) s[BW + 4*d +: 4] = s[BW + 4*d +: 4] - 4'd3;
        end
        return s;
    endfunction

    assign w_bcd_bad  = f_bcd_invalid(s_if.bcd);
    assign w_sr_shift = f_shift_fix(r_sr);
    assign w_last     = (r_cnt == CNT_W'(BW - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; START is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (s_if.start) w_state_nxt = w_bcd_bad ? S_FIN : S_CONV;
            S_CONV: if (w_last)     w_state_nxt = S_FIN;
            S_FIN:                  w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_CONV:  w_busy = 1'b1;
            S_FIN:   w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load, shift/correct, and capture the result on entry to FIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_bin <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_if.start) begin
                        if (w_bcd_bad) begin
                            r_bin <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_sr  <= {s_if.bcd, {BW{1'b0}}};
                            r_cnt <= '0;
                        end
                    end
                end
                S_CONV: begin
                    r_sr  <= w_sr_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bin <= w_sr_shift[BW-1:0];
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A valid word must leave nothing behind in the BCD field after the last shift.
    a_bcd_drained: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == S_CONV && w_last) |-> (w_sr_shift[SR_W-1:BW] == '0));

    assign s_if.busy = w_busy;
    assign s_if.done = w_done;
    assign s_if.err  = r_err;
    assign s_if.bin  = r_bin;
endmodule
